banked_reg_file: RTL
====================

# banked_reg_file

Parametrised two-bank (integer/float) register file for the modified MIPS datapath, the successor of the fixed 32x32 dual-read register file. It provides N_RD independent read ports, each with its own bank select, and one write port. Reads are registered on the rising edge with same-cycle write bypass. The integer register 0 can be hardwired to zero. Synchronous reset starts a sweep state machine that clears both banks one address per cycle and signals completion on `ready`. The block sits between decode (read addresses) and write-back (write port).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers per bank
- N_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = integer register 0 reads 0 and ignores writes; float bank unaffected
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- regWrite  in  1  write enable
- float  in  1  write bank select: 0 = integer, 1 = float
- writeReg  in  ADDR_W  write address
- writeData  in  DATA_W  write data
- readReg  in  N_RD*ADDR_W  read addresses; port p occupies bits [p*ADDR_W +: ADDR_W]
- readFloat  in  N_RD  per-port bank select; bit p selects the bank for port p
- dataOut  out  N_RD*DATA_W  registered read data; port p occupies bits [p*DATA_W +: DATA_W]
- ready  out  1  high when the clear sweep is done and the register file accepts reads and writes

## Operation
- State machine: two states, CLEAR and RUN; clear counter `clr_addr` is ADDR_W bits wide.
- Rising edge with rst_n=0:
  - state <= CLEAR, clr_addr <= 0, ready <= 0, dataOut <= 0.
  - Register contents are not touched on this edge.
  - This holds for as long as rst_n stays low.
- CLEAR state, rising edge with rst_n=1:
  - Both registers_i[clr_addr] and registers_f[clr_addr] are set to 0.
  - clr_addr increments.
  - When clr_addr == DEPTH-1: state <= RUN and ready <= 1 on that same edge.
  - Writes are ignored and dataOut is held at 0 throughout CLEAR.
- RUN state, write:
  - If regWrite=1, the selected bank entry writeReg takes writeData.
  - Exception: when ZERO_REG=1, float=0 and writeReg=0, the write is dropped.
- RUN state, read (port p, evaluated independently for every port each edge), in priority order:
  1. If ZERO_REG=1, readFloat[p]=0 and the address is 0: result is 0.
  2. Else if regWrite=1, float==readFloat[p] and writeReg matches the address: result is writeData (bypass).
  3. Else: result is the stored value from the selected bank.
  - The result is registered into dataOut slice p.
- Banks are fully isolated: an integer write never affects float reads at the same address, and vice versa.
- Several ports may read the same address in the same cycle; all of them receive the same value.
- Reset mid-operation (RUN or CLEAR): the next low edge re-enters CLEAR and restarts the sweep from address 0; a partial sweep is discarded.

## Timing
- Reset to ready: ready rises on the DEPTH-th rising edge with rst_n=1 after reset (32 edges when ADDR_W=5).
- Read latency is 1 cycle: an address presented before edge k appears on dataOut after edge k and stays until the next edge.
- Write latency: data is stored at edge k. A read sampled at edge k sees it via bypass; a read sampled at edge k+1 sees it from storage.
- There is no stall or back-pressure. A write or read is accepted on every RUN cycle.
- Output values after reset: ready=0 and dataOut=0 until the first RUN-cycle read.

## Test plan
- Reset sweep (ADDR_W=5): hold rst_n=0 for 3 edges, then release.
  - ready must be 0 for 31 edges and 1 at the 32nd.
  - Then read all 32 integer and all 32 float registers: every value must be 0.
- Write then read:
  - Write integer r5 = 0xDEADBEEF.
  - Next cycle, read port0 = int r5 and port1 = float r5.
  - Required: port0 = 0xDEADBEEF and port1 = 0.
- Bypass:
  - In the same cycle, write float r7 = 0x3F800000 and read port1 = float r7.
  - Required: dataOut port1 = 0x3F800000 one edge later.
  - Repeat with the read on int r7: the result must be the old integer value.
- Zero register (ZERO_REG=1):
  - Write int r0 = 0xFFFFFFFF, then read int r0: required 0.
  - Write float r0 = 0x12345678, then read float r0: required 0x12345678.
- Reset mid-sweep:
  - Release reset, wait 10 edges, then assert rst_n for 1 edge.
  - Required: ready stays 0 and rises exactly 32 edges after the second release.
  - Any write issued during CLEAR must not be observable afterwards.
- N_RD=3: three ports read int r1, float r1 and int r1 after writing int r1 = 0xA5A5A5A5.
  - Required: 0xA5A5A5A5, 0, 0xA5A5A5A5, all in the same cycle.

Source files
------------

// File: rtl/banked_reg_file.sv
// banked_reg_file
// ---------------
// Two-bank register file (integer bank and float bank) for the MIPS datapath.
// It has N_RD registered read ports, one write port and a bypass path from
// the write port to the read ports in the same cycle. Integer register 0 can
// be hardwired to zero. A synchronous reset starts a sweep that clears both
// banks, one address per cycle. `ready` goes high when the sweep is done.
//
// Handshake: there is no valid/ready pairing and no back-pressure. Once
// `ready` is high, the block accepts a read on every port and a write on
// every rising edge. While `ready` is low, writes are dropped and dataOut
// reads as zero.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   rst_n      : synchronous active-low reset
//   regWrite   : write enable
//   float      : write bank select (0 = integer, 1 = float)
//   writeReg   : write address
//   writeData  : write data
//   readReg    : read addresses, port p at [p*ADDR_W +: ADDR_W]
//   readFloat  : per-port read bank select, bit p for port p
//   dataOut    : registered read data, port p at [p*DATA_W +: DATA_W]
//   ready      : clear sweep finished, register file in service
module banked_reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_RD     = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     regWrite,
  input  logic                     float,
  input  logic [ADDR_W-1:0]        writeReg,
  input  logic [DATA_W-1:0]        writeData,
  input  logic [N_RD*ADDR_W-1:0]   readReg,
  input  logic [N_RD-1:0]          readFloat,
  output logic [N_RD*DATA_W-1:0]   dataOut,
  output logic                     ready
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Sweep/service state. It stays a named flop so that checkers can bind to it.
  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      clr_addr_q, clr_addr_d;
  logic                   ready_q, ready_d;
  logic [N_RD*DATA_W-1:0] data_out_q, data_out_d;

  logic [DATA_W-1:0] regs_i_q [DEPTH];
  logic [DATA_W-1:0] regs_i_d [DEPTH];
  logic [DATA_W-1:0] regs_f_q [DEPTH];
  logic [DATA_W-1:0] regs_f_d [DEPTH];

  // An integer write to r0 is discarded when r0 is hardwired to zero.
  logic wr_drop;
  assign wr_drop = (ZERO_REG != 0) && !float && (writeReg == '0);

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    ready_d    = ready_q;
    data_out_d = data_out_q;
    regs_i_d   = regs_i_q;
    regs_f_d   = regs_f_q;

    case (state_q)
      CLEAR: begin
        regs_i_d[clr_addr_q] = '0;
        regs_f_d[clr_addr_q] = '0;
        clr_addr_d           = clr_addr_q + 1'b1;
        data_out_d           = '0;
        // All ones means DEPTH-1 is being cleared on this edge, which is the last address.
        if (&clr_addr_q) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end

      RUN: begin
        ready_d = 1'b1;

        if (regWrite && !wr_drop) begin
          if (float) regs_f_d[writeReg] = writeData;
          else       regs_i_d[writeReg] = writeData;
        end

        // Each port resolves independently: zero register first, then the
        // same-cycle bypass, then the value in storage. Storage is read from
        // the _q copy, so a write on this edge is visible only through the bypass.
        for (int p = 0; p < N_RD; p++) begin
          if ((ZERO_REG != 0) && !readFloat[p] &&
              (readReg[p*ADDR_W +: ADDR_W] == '0)) begin
            data_out_d[p*DATA_W +: DATA_W] = '0;
          end else if (regWrite && (float == readFloat[p]) &&
                       (writeReg == readReg[p*ADDR_W +: ADDR_W])) begin
            data_out_d[p*DATA_W +: DATA_W] = writeData;
          end else if (readFloat[p]) begin
            data_out_d[p*DATA_W +: DATA_W] = regs_f_q[readReg[p*ADDR_W +: ADDR_W]];
          end else begin
            data_out_d[p*DATA_W +: DATA_W] = regs_i_q[readReg[p*ADDR_W +: ADDR_W]];
          end
        end
      end

      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  // Reset does not change the register contents. The sweep that follows reset clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= CLEAR;
      clr_addr_q <= '0;
      ready_q    <= 1'b0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      ready_q    <= ready_d;
      data_out_q <= data_out_d;
      regs_i_q   <= regs_i_d;
      regs_f_q   <= regs_f_d;
    end
  end

  assign dataOut = data_out_q;
  assign ready   = ready_q;

endmodule
